matrix_stream_loader: RTL and testbench

Parametrised successor to the two-matrix nibble loader. Accepts a framed stream of header words (R1, C1, R2, C2) and element words over a valid/ready handshake. Checks the dimensions and stores matrix A and matrix B row-major in internal buffers. Asserts `ready` to the multiplier stage and holds the data stable until the multiplier acknowledges with `ack`, which releases the buffers for the next load.

---
 rtl/matrix_stream_loader.sv | 181 ++++++++++++++++++
 tb/tb_matrix_stream_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - framed header/element stream loader for two row-major matrix buffers
module matrix_stream_loader #(
  parameter int DATA_W  = 4,
  parameter int MAX_DIM = 4,
  parameter int DIM_W   = 4
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   in_valid,
  input  logic                                   in_hdr,
  input  logic [DATA_W-1:0]                      in_data,
  output logic                                   in_ready,
  output logic [DIM_W-1:0]                       R1,
  output logic [DIM_W-1:0]                       C1,
  output logic [DIM_W-1:0]                       R2,
  output logic [DIM_W-1:0]                       C2,
  output logic                                   ready,
  input  logic                                   ack,
  output logic                                   err,
  output logic [1:0]                             err_code,
  input  logic                                   rd_sel,
  input  logic [$clog2(MAX_DIM*MAX_DIM)-1:0]     rd_addr,
  output logic [DATA_W-1:0]                      rd_data
);

  localparam int DEPTH  = MAX_DIM * MAX_DIM;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int PROD_W = 2 * DIM_W;

  typedef enum logic [2:0] {S_HDR, S_LOAD_A, S_LOAD_B, S_READY, S_ERROR} state_t;

  state_t              state, state_d;
  logic [1:0]          hcnt;
  logic [CNT_W-1:0]    idx;
  logic                hdr_oor;
  logic [1:0]          code_d;
  logic [DATA_W-1:0]   mem_a [DEPTH];
  logic [DATA_W-1:0]   mem_b [DEPTH];

  logic                beat;
  logic [DIM_W-1:0]    hdr_word;
  logic                word_oor;
  logic                range_fault;
  logic                mismatch;
  logic [PROD_W-1:0]   prod_a, prod_b;
  logic                last_a, last_b;

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (d > DIM_W'(MAX_DIM));
  endfunction

  assign in_ready = !RST && (state != S_READY);
  assign beat     = in_valid && in_ready;
  assign ready    = (state == S_READY);
  assign err      = (state == S_ERROR);

  // Header word checks; the 4th word is checked live as C2 before it is latched.
  assign hdr_word    = in_data[DIM_W-1:0];
  assign word_oor    = (in_data >> DIM_W) != '0;
  assign range_fault = hdr_oor || word_oor || dim_bad(R1) || dim_bad(C1) ||
                       dim_bad(R2) || dim_bad(hdr_word);
  assign mismatch    = (C1 != R2);

  assign prod_a = PROD_W'(R1) * PROD_W'(C1);
  assign prod_b = PROD_W'(R2) * PROD_W'(C2);
  assign last_a = (32'(idx) == 32'(prod_a) - 32'd1);
  assign last_b = (32'(idx) == 32'(prod_b) - 32'd1);

  // State register and sticky error code.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_HDR;
      err_code <= 2'd0;
    end else begin
      state    <= state_d;
      err_code <= code_d;
    end
  end

  // Next-state decode; range faults take priority over the C1/R2 mismatch.
  always_comb begin
    state_d = state;
    code_d  = err_code;
    case (state)
      S_HDR: begin
        if (beat) begin
          if (!in_hdr) begin
            state_d = S_ERROR;
            code_d  = 2'd3;
          end else if (hcnt == 2'd3) begin
            if (range_fault) begin
              state_d = S_ERROR;
              code_d  = 2'd1;
            end else if (mismatch) begin
              state_d = S_ERROR;
              code_d  = 2'd2;
            end else begin
              state_d = S_LOAD_A;
            end
          end
        end
      end
      S_LOAD_A: begin
        if (beat) begin
          if (in_hdr) begin
            state_d = S_ERROR;
            code_d  = 2'd3;
          end else if (last_a) begin
            state_d = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: begin
        if (beat) begin
          if (in_hdr) begin
            state_d = S_ERROR;
            code_d  = 2'd3;
          end else if (last_b) begin
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (ack) state_d = S_HDR;
      end
      S_ERROR: begin
        if (ack) begin
          state_d = S_HDR;
          code_d  = 2'd0;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // Header latching and counters; any state change restarts both counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt    <= 2'd0;
      idx     <= '0;
      hdr_oor <= 1'b0;
      R1      <= '0;
      C1      <= '0;
      R2      <= '0;
      C2      <= '0;
    end else begin
      if (state == S_HDR && beat && in_hdr) begin
        case (hcnt)
          2'd0:    R1 <= hdr_word;
          2'd1:    C1 <= hdr_word;
          2'd2:    R2 <= hdr_word;
          default: C2 <= hdr_word;
        endcase
        hcnt    <= hcnt + 2'd1;
        hdr_oor <= (hcnt == 2'd0) ? word_oor : (hdr_oor || word_oor);
      end
      if ((state == S_LOAD_A || state == S_LOAD_B) && beat && !in_hdr)
        idx <= idx + 1'b1;
      if (state_d != state) begin
        hcnt <= 2'd0;
        idx  <= '0;
      end
    end
  end

  // Element buffers; contents survive reset and ack.
  always_ff @(posedge CLK) begin
    if (beat && !in_hdr) begin
      if (state == S_LOAD_A) mem_a[idx[ADDR_W-1:0]] <= in_data;
      if (state == S_LOAD_B) mem_b[idx[ADDR_W-1:0]] <= in_data;
    end
  end

  // Registered read port; a same-cycle write to the same entry returns old data.
  always_ff @(posedge CLK) begin
    if (RST) rd_data <= '0;
    else     rd_data <= rd_sel ? mem_b[rd_addr] : mem_a[rd_addr];
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb/tb_matrix_stream_loader.sv - self-checking bench for matrix_stream_loader
module tb_matrix_stream_loader;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_hdr = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready;
  logic [3:0] R1, C1, R2, C2;
  logic       ready;
  logic       ack = 1'b0;
  logic       err;
  logic [1:0] err_code;
  logic       rd_sel = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [3:0] rd_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  matrix_stream_loader #(.DATA_W(4), .MAX_DIM(4), .DIM_W(4)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_hdr(in_hdr), .in_data(in_data),
    .in_ready(in_ready), .R1(R1), .C1(C1), .R2(R2), .C2(C2), .ready(ready), .ack(ack),
    .err(err), .err_code(err_code), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [3:0] r1, c1, r2, c2;
    logic       exp_err;
    logic [1:0] exp_code;
  } hv_t;

  hv_t vec[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; in_valid = 1'b0; ack = 1'b0; in_hdr = 1'b0; in_data = 4'd0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic send(input logic h, input logic [3:0] d);
    int n;
    in_valid = 1'b1; in_hdr = h; in_data = d; n = 0;
    @(negedge CLK);
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    send(1'b1, a); send(1'b1, b); send(1'b1, c); send(1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic rd(input logic s, input logic [3:0] a, output logic [3:0] d);
    rd_sel = s; rd_addr = a;
    @(posedge CLK); #1;
    d = rd_data;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(posedge CLK); #1;
    ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    int c0;

    vec[0] = '{"hdr_2222",    4'd2, 4'd2, 4'd2, 4'd2, 1'b0, 2'd0};
    vec[1] = '{"hdr_1111",    4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 2'd0};
    vec[2] = '{"hdr_4444",    4'd4, 4'd4, 4'd4, 4'd4, 1'b0, 2'd0};
    vec[3] = '{"hdr_2322",    4'd2, 4'd3, 4'd2, 4'd2, 1'b1, 2'd2};
    vec[4] = '{"hdr_r1_zero", 4'd0, 4'd2, 4'd2, 4'd2, 1'b1, 2'd1};
    vec[5] = '{"hdr_c2_five", 4'd2, 4'd2, 4'd2, 4'd5, 1'b1, 2'd1};
    vec[6] = '{"hdr_both",    4'd5, 4'd3, 4'd2, 4'd2, 1'b1, 2'd1};
    vec[7] = '{"hdr_2232",    4'd2, 4'd2, 4'd3, 4'd2, 1'b1, 2'd2};

    // Reset state
    @(negedge CLK);
    check("in_ready_in_reset", in_ready, 0);
    @(posedge CLK); #1;
    check("rst_R1", R1, 0); check("rst_C1", C1, 0);
    check("rst_R2", R2, 0); check("rst_C2", C2, 0);
    check("rst_ready", ready, 0); check("rst_err", err, 0);
    check("rst_err_code", err_code, 0); check("rst_rd_data", rd_data, 0);
    RST = 1'b0; #1;
    check("in_ready_after_reset", in_ready, 1);

    // Header table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send_hdr(vec[i].r1, vec[i].c1, vec[i].r2, vec[i].c2);
      check({vec[i].name, "_err"}, err, vec[i].exp_err);
      check({vec[i].name, "_code"}, err_code, vec[i].exp_code);
      check({vec[i].name, "_R1"}, R1, vec[i].r1);
      check({vec[i].name, "_C2"}, C2, vec[i].c2);
      check({vec[i].name, "_in_ready"}, in_ready, 1);
      if (vec[i].exp_err) begin
        ack_pulse();
        check({vec[i].name, "_ack_err"}, err, 0);
        check({vec[i].name, "_ack_code"}, err_code, 0);
      end
    end

    // 2x2 * 2x2, back-to-back
    do_reset();
    c0 = cyc;
    send_hdr(4'd2, 4'd2, 4'd2, 4'd2);
    for (int k = 1; k <= 7; k++) send(1'b0, 4'(k));
    check("b2b_ready_before_last", ready, 0);
    send(1'b0, 4'd8);
    check("b2b_ready", ready, 1);
    check("b2b_in_ready", in_ready, 0);
    check("b2b_zero_bubble", cyc - c0, 12);
    for (int k = 0; k < 4; k++) begin
      rd(1'b0, 4'(k), d); check("b2b_A", d, k + 1);
      rd(1'b1, 4'(k), d); check("b2b_B", d, k + 5);
    end

    // Back-pressure while READY
    in_valid = 1'b1; in_hdr = 1'b0; in_data = 4'd15;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_in_ready", in_ready, 0);
      check("bp_ready", ready, 1);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    rd(1'b1, 4'd0, d); check("bp_B0", d, 5);
    rd(1'b0, 4'd3, d); check("bp_A3", d, 4);
    ack_pulse();
    check("ack_ready", ready, 0);
    check("ack_in_ready", in_ready, 1);
    c0 = cyc;
    send(1'b1, 4'd1);
    check("ack_hdr_latency", cyc - c0, 1);
    rd(1'b0, 4'd2, d); check("old_A2", d, 3);
    send(1'b1, 4'd1); send(1'b1, 4'd1); send(1'b1, 4'd1);
    send(1'b0, 4'd9); send(1'b0, 4'd10);
    check("reload_ready", ready, 1);
    check("reload_R1", R1, 1);
    rd(1'b0, 4'd0, d); check("reload_A0", d, 9);
    rd(1'b1, 4'd0, d); check("reload_B0", d, 10);

    // 3x2 * 2x4 with random gaps
    do_reset();
    send_hdr(4'd3, 4'd2, 4'd2, 4'd4);
    for (int k = 1; k <= 14; k++) begin
      idle(int'($urandom_range(0, 2)));
      if (k == 14) check("gap_ready_before_last", ready, 0);
      send(1'b0, 4'(k));
    end
    check("gap_ready", ready, 1);
    rd(1'b1, 4'd5, d); check("gap_B5", d, 12);
    rd(1'b0, 4'd5, d); check("gap_A5", d, 6);
    check("gap_C2", C2, 4);

    // Header beat inside LOAD_A, then element beat in HDR
    do_reset();
    send_hdr(4'd2, 4'd2, 4'd2, 4'd2);
    send(1'b0, 4'd1);
    send(1'b1, 4'd2);
    check("seq_err", err, 1);
    check("seq_code", err_code, 3);
    send(1'b0, 4'd3); send(1'b1, 4'd4); send(1'b0, 4'd5);
    check("discard_err", err, 1);
    check("discard_code", err_code, 3);
    check("discard_ready", ready, 0);
    ack_pulse();
    check("seq_ack_err", err, 0);
    check("seq_ack_code", err_code, 0);
    check("seq_ack_in_ready", in_ready, 1);
    send(1'b0, 4'd5);
    check("elem_in_hdr_code", err_code, 3);
    ack_pulse();

    // Reset mid-load, then a fresh load
    do_reset();
    send_hdr(4'd2, 4'd2, 4'd2, 4'd2);
    send(1'b0, 4'd7); send(1'b0, 4'd7); send(1'b0, 4'd7);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_in_ready", in_ready, 0);
    @(posedge CLK); #1;
    check("midrst_R1", R1, 0);
    check("midrst_C1", C1, 0);
    check("midrst_ready", ready, 0);
    check("midrst_err", err, 0);
    RST = 1'b0; #1;
    check("midrst_in_ready_after", in_ready, 1);
    send_hdr(4'd2, 4'd2, 4'd2, 4'd2);
    rd_sel = 1'b0; rd_addr = 4'd0;
    send(1'b0, 4'd11);
    check("rw_same_entry_old", rd_data, 7);
    send(1'b0, 4'd12); send(1'b0, 4'd13); send(1'b0, 4'd14);
    for (int k = 5; k <= 8; k++) send(1'b0, 4'(k));
    check("fresh_ready", ready, 1);
    rd(1'b0, 4'd0, d); check("fresh_A0", d, 11);
    rd(1'b1, 4'd3, d); check("fresh_B3", d, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
